// File: rtl/act_pipe_arr_if.sv
// Handshake bundle for act_pipe_arr: the input beat with its per-beat
// activation config on one side, the activated beat and its zero count
// on the other.
interface act_pipe_arr_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ARR_INPUTS = 16
);
  localparam int ZW  = $clog2(ARR_INPUTS + 1);
  localparam int LSW = $clog2(DATA_WIDTH);
  localparam int VW  = DATA_WIDTH * ARR_INPUTS;

  logic                         in_valid;
  logic                         in_ready;
  logic [VW-1:0]                in_data;
  logic [1:0]                   mode;
  logic [LSW-1:0]               leak_shift;
  logic signed [DATA_WIDTH-1:0] clip;
  logic                         out_valid;
  logic                         out_ready;
  logic [VW-1:0]                out_data;
  logic [ZW-1:0]                out_zero_cnt;

  // Producer of input beats and consumer of output beats.
  modport master (
    output in_valid, in_data, mode, leak_shift, clip, out_ready,
    input  in_ready, out_valid, out_data, out_zero_cnt
  );

  // The activation block itself.
  modport slave (
    input  in_valid, in_data, mode, leak_shift, clip, out_ready,
    output in_ready, out_valid, out_data, out_zero_cnt
  );
endinterface

// File: rtl/act_pipe_arr.sv
// Two-stage activation array (bypass / ReLU / leaky / clamp) between the
// systolic accumulators and the output buffer. Valid/ready on both sides,
// no skid buffer: in_ready follows out_ready combinationally. Saturating
// beat and zero-lane counters support sparsity profiling.
module act_pipe_arr #(
  parameter int DATA_WIDTH = 16,
  parameter int ARR_INPUTS = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  act_pipe_arr_if.slave        bus,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] stat_beats,
  output logic [CNT_WIDTH-1:0] stat_zeros
);
  localparam int ZW  = $clog2(ARR_INPUTS + 1);
  localparam int LSW = $clog2(DATA_WIDTH);
  localparam int VW  = DATA_WIDTH * ARR_INPUTS;
  localparam int SW  = ((CNT_WIDTH > ZW) ? CNT_WIDTH : ZW) + 1;

  // One lane of activation. Negativity is taken from the sign bit; the
  // leaky path relies on >>> of a signed operand rounding toward -inf.
  function automatic logic signed [DATA_WIDTH-1:0] act_lane(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [1:0]                   m,
    input logic [LSW-1:0]               sh,
    input logic signed [DATA_WIDTH-1:0] c
  );
    logic signed [DATA_WIDTH-1:0] y;
    y = x;
    case (m)
      2'b01:   y = x[DATA_WIDTH-1] ? '0 : x;
      2'b10:   y = x[DATA_WIDTH-1] ? (x >>> sh) : x;
      2'b11: begin
        // A non-positive clip forces every lane to zero.
        if (x[DATA_WIDTH-1] || c[DATA_WIDTH-1] || (c == '0)) y = '0;
        else                                                 y = (x < c) ? x : c;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [ZW-1:0]        b
  );
    logic [SW-1:0] s;
    logic [SW-1:0] mx;
    s  = SW'(a) + SW'(b);
    mx = SW'({CNT_WIDTH{1'b1}});
    return (s > mx) ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  logic                         vld_p1_q, vld_p1_d;
  logic [VW-1:0]                data_p1_q, data_p1_d;
  logic [1:0]                   mode_p1_q, mode_p1_d;
  logic [LSW-1:0]               shift_p1_q, shift_p1_d;
  logic signed [DATA_WIDTH-1:0] clip_p1_q, clip_p1_d;
  logic                         vld_p2_q, vld_p2_d;
  logic [VW-1:0]                data_p2_q, data_p2_d;
  logic [ZW-1:0]                zcnt_p2_q, zcnt_p2_d;
  logic [CNT_WIDTH-1:0]         beats_q, beats_d;
  logic [CNT_WIDTH-1:0]         zeros_q, zeros_d;

  logic                         s1_adv, s2_adv, out_xfer;
  logic [VW-1:0]                act_p1;
  logic [ZW-1:0]                zcnt_p1;
  logic signed [DATA_WIDTH-1:0] lane_y;

  // Advance chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    s2_adv   = !vld_p2_q || bus.out_ready;
    s1_adv   = !vld_p1_q || s2_adv;
    out_xfer = vld_p2_q && bus.out_ready;
  end

  // Stage 1 -> stage 2: activate every lane with the beat's own config and
  // count the zero results so the count lands alongside the data.
  always_comb begin
    act_p1  = '0;
    zcnt_p1 = '0;
    lane_y  = '0;
    for (int i = 0; i < ARR_INPUTS; i++) begin
      lane_y = act_lane(data_p1_q[i*DATA_WIDTH +: DATA_WIDTH], mode_p1_q,
                        shift_p1_q, clip_p1_q);
      act_p1[i*DATA_WIDTH +: DATA_WIDTH] = lane_y;
      if (lane_y == '0) zcnt_p1 = zcnt_p1 + ZW'(1);
    end
  end

  // Next-state for both stages and the statistics; stalled stages hold.
  always_comb begin
    vld_p1_d   = vld_p1_q;
    data_p1_d  = data_p1_q;
    mode_p1_d  = mode_p1_q;
    shift_p1_d = shift_p1_q;
    clip_p1_d  = clip_p1_q;
    vld_p2_d   = vld_p2_q;
    data_p2_d  = data_p2_q;
    zcnt_p2_d  = zcnt_p2_q;
    beats_d    = beats_q;
    zeros_d    = zeros_q;

    if (s1_adv) begin
      vld_p1_d   = bus.in_valid;
      data_p1_d  = bus.in_data;
      mode_p1_d  = bus.mode;
      shift_p1_d = bus.leak_shift;
      clip_p1_d  = bus.clip;
    end

    if (s2_adv) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = act_p1;
      zcnt_p2_d = zcnt_p1;
    end

    // Clear wins over a same-cycle increment.
    if (stat_clear) begin
      beats_d = '0;
      zeros_d = '0;
    end else if (out_xfer) begin
      beats_d = sat_add(beats_q, ZW'(1));
      zeros_d = sat_add(zeros_q, zcnt_p2_q);
    end
  end

  // Pipeline and counter registers; reset empties the pipe and zeroes all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      data_p1_q  <= '0;
      mode_p1_q  <= '0;
      shift_p1_q <= '0;
      clip_p1_q  <= '0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      zcnt_p2_q  <= '0;
      beats_q    <= '0;
      zeros_q    <= '0;
    end else begin
      // stage 1 register
      vld_p1_q   <= vld_p1_d;
      data_p1_q  <= data_p1_d;
      mode_p1_q  <= mode_p1_d;
      shift_p1_q <= shift_p1_d;
      clip_p1_q  <= clip_p1_d;
      // stage 2 register
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      zcnt_p2_q  <= zcnt_p2_d;
      // statistics
      beats_q    <= beats_d;
      zeros_q    <= zeros_d;
    end
  end

  assign bus.in_ready     = s1_adv;
  assign bus.out_valid    = vld_p2_q;
  assign bus.out_data     = data_p2_q;
  assign bus.out_zero_cnt = zcnt_p2_q;
  assign stat_beats       = beats_q;
  assign stat_zeros       = zeros_q;
endmodule

// File: tb/tb_act_pipe_arr.sv
// Bench for act_pipe_arr: directed vectors, a lane-level reference model
// with an expected-beat queue, and literal expectations from hand math.
module tb_act_pipe_arr;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int VW = DW * N;

  logic clk = 1'b0;
  logic rst_n;
  logic stat_clear;
  logic [31:0] stat_beats, stat_zeros;
  logic b_clear;
  logic [3:0] b_beats, b_zeros;

  act_pipe_arr_if #(.DATA_WIDTH(DW), .ARR_INPUTS(N)) bus ();
  act_pipe_arr_if #(.DATA_WIDTH(DW), .ARR_INPUTS(N)) bb ();

  act_pipe_arr #(.DATA_WIDTH(DW), .ARR_INPUTS(N), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stat_clear(stat_clear),
    .stat_beats(stat_beats), .stat_zeros(stat_zeros));

  act_pipe_arr #(.DATA_WIDTH(DW), .ARR_INPUTS(N), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bb), .stat_clear(b_clear),
    .stat_beats(b_beats), .stat_zeros(b_zeros));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Reference lane: written from the activation rules with integer math;
  // leaky uses floor division by 2^s rather than a shift.
  function automatic int model_lane(input int x, input int m, input int s, input int c);
    int p;
    p = 1 << s;
    case (m)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? -((-x + p - 1) / p) : x;
      default: begin
        if (x < 0 || c <= 0) return 0;
        return (x < c) ? x : c;
      end
    endcase
  endfunction

  task automatic model_beat(input logic [VW-1:0] d, input int m, input int s, input int c,
                            output logic [VW-1:0] y, output int zc);
    logic signed [DW-1:0] xs;
    int r;
    logic [31:0] rv;
    y  = '0;
    zc = 0;
    for (int i = 0; i < N; i++) begin
      xs = d[i*DW +: DW];
      r  = model_lane(int'(xs), m, s, c);
      rv = r;
      y[i*DW +: DW] = rv[DW-1:0];
      if (r == 0) zc++;
    end
  endtask

  typedef struct {
    logic [VW-1:0] d;
    int            zc;
    int            acc;
  } exp_t;

  exp_t q[$];
  longint mb, mz;
  bit lat_strict = 1'b0;
  localparam longint CMAX = 64'hFFFF_FFFF;

  // Single compare process: checks every meaningful output cycle against the
  // model queue and the model counters, then advances the model.
  always @(negedge clk) begin
    exp_t e;
    logic [VW-1:0] y;
    int zc;
    if (!rst_n) begin
      q.delete();
      mb = 0;
      mz = 0;
      check("rst_out_valid", VW'(bus.out_valid), VW'(0));
      check("rst_in_ready", VW'(bus.in_ready), VW'(1));
      check("rst_out_data", bus.out_data, '0);
      check("rst_zero_cnt", VW'(bus.out_zero_cnt), VW'(0));
      check("rst_stats", VW'({stat_beats, stat_zeros}), VW'(0));
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) check("spurious_out_valid", VW'(1), VW'(0));
        else begin
          check("out_data", bus.out_data, q[0].d);
          check("out_zero_cnt", VW'(bus.out_zero_cnt), VW'(q[0].zc));
        end
      end
      check("stat_beats", VW'(stat_beats), VW'(mb));
      check("stat_zeros", VW'(stat_zeros), VW'(mz));
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        if (lat_strict) check("latency", VW'(cyc - e.acc), VW'(2));
        mb = (mb + 1 > CMAX) ? CMAX : mb + 1;
        mz = (mz + e.zc > CMAX) ? CMAX : mz + e.zc;
      end
      if (stat_clear) begin
        mb = 0;
        mz = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        model_beat(bus.in_data, int'(bus.mode), int'(bus.leak_shift), int'(bus.clip), y, zc);
        e.d = y; e.zc = zc; e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  function automatic logic [VW-1:0] bcast(input int v);
    logic [VW-1:0] r;
    logic [31:0] t;
    t = v;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = t[DW-1:0];
    return r;
  endfunction

  task automatic drive(input bit v, input logic [VW-1:0] d, input logic [1:0] m,
                       input logic [3:0] s, input logic signed [DW-1:0] c);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data = d;
    bus.mode = m;
    bus.leak_shift = s;
    bus.clip = c;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 2'b00, 4'd0, '0);
  endtask

  // Isolated beat: checks acceptance, 2-cycle latency and literal results.
  task automatic lat_beat(input string nm, input logic [VW-1:0] d, input logic [1:0] m,
                          input logic [3:0] s, input logic signed [DW-1:0] c,
                          input logic [VW-1:0] exp_d, input int exp_z);
    int c0;
    bit got;
    drive(1'b1, d, m, s, c);
    @(negedge clk);
    c0 = cyc;
    check({nm, "_accept"}, VW'(bus.in_ready), VW'(1));
    drive(1'b0, '0, 2'b00, 4'd0, '0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) check({nm, "_timeout"}, VW'(0), VW'(1));
    else begin
      check({nm, "_lat"}, VW'(cyc - c0), VW'(2));
      check({nm, "_data"}, bus.out_data, exp_d);
      check({nm, "_zc"}, VW'(bus.out_zero_cnt), VW'(exp_z));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int vals[7] = '{-300, -1, 0, 5, 1000, 32767, -32768};
  int e_m1[7] = '{0, 0, 0, 5, 1000, 32767, 0};
  int e_m2[7] = '{-38, -1, 0, 5, 1000, 32767, -4096};
  int e_m3[7] = '{0, 0, 0, 5, 255, 255, 0};

  initial begin
    logic [VW-1:0] d;
    int sent;
    bit saw_low;

    // Pin the reference model to hand-computed lane results.
    for (int i = 0; i < 7; i++) begin
      check("pin_m0", VW'(model_lane(vals[i], 0, 3, 255)), VW'(vals[i]));
      check("pin_m1", VW'(model_lane(vals[i], 1, 3, 255)), VW'(e_m1[i]));
      check("pin_m2", VW'(model_lane(vals[i], 2, 3, 255)), VW'(e_m2[i]));
      check("pin_m3", VW'(model_lane(vals[i], 3, 3, 255)), VW'(e_m3[i]));
    end

    rst_n = 1'b0;
    stat_clear = 1'b0;
    b_clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = '0; bus.leak_shift = '0;
    bus.clip = '0; bus.out_ready = 1'b1;
    bb.in_valid = 1'b0; bb.in_data = '0; bb.mode = '0; bb.leak_shift = '0;
    bb.clip = '0; bb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", VW'(bus.in_ready), VW'(1));
    check("idle_out_valid", VW'(bus.out_valid), VW'(0));
    check("idle_stat_beats", VW'(stat_beats), VW'(0));
    idle(2);

    // Mode sweep, back to back, all lanes carrying the same value.
    lat_strict = 1'b1;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 7; i++)
        drive(1'b1, bcast(vals[i]), m[1:0], 4'd3, 16'sd255);
    idle(4);

    lat_beat("leaky_m300", bcast(-300), 2'b10, 4'd3, 16'sd255, bcast(-38), 0);
    lat_beat("leaky_min", bcast(-32768), 2'b10, 4'd3, 16'sd255, bcast(-4096), 0);
    lat_beat("clamp_1000", bcast(1000), 2'b11, 4'd3, 16'sd255, bcast(255), 0);
    lat_beat("leaky_s0", bcast(-300), 2'b10, 4'd0, 16'sd0, bcast(-300), 0);
    for (int i = 0; i < N; i++) d[i*DW +: DW] = 16'(i * 1000 - 7000);
    lat_beat("clip_neg", d, 2'b11, 4'd2, -16'sd5, '0, N);

    // Per-beat config alternating ReLU / clamp with different clips.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) d[i*DW +: DW] = 16'(i * 37 - 200 + k);
      drive(1'b1, d, (k % 2 == 0) ? 2'b01 : 2'b11, 4'd1,
            (k % 2 == 0) ? 16'sd100 : 16'sd7);
    end
    idle(4);

    // Backpressure: 10 beats, out_ready low for loop cycles 3..8.
    lat_strict = 1'b0;
    @(posedge clk); #1 stat_clear = 1'b1;
    @(posedge clk); #1 stat_clear = 1'b0;
    sent = 0;
    saw_low = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      bus.out_ready = !(k >= 3 && k <= 8);
      if (sent < 10) begin
        for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = 16'(sent * 1000 + i * 13 - 100);
        bus.in_valid = 1'b1;
        bus.mode = 2'(sent % 4);
        bus.leak_shift = 4'(sent % 8);
        bus.clip = 16'(sent * 50 - 100);
      end else bus.in_valid = 1'b0;
      @(negedge clk);
      if (!bus.in_ready) saw_low = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    check("bp_in_ready_fell", VW'(saw_low), VW'(1));
    check("bp_sent", VW'(sent), VW'(10));
    check("bp_stat_beats", VW'(stat_beats), VW'(10));
    bus.out_ready = 1'b1;
    idle(2);
    lat_strict = 1'b1;

    // Counters: beats with 3, 0, 16 and 5 zero lanes.
    @(posedge clk); #1 stat_clear = 1'b1;
    @(posedge clk); #1 stat_clear = 1'b0;
    begin
      int nz[4] = '{3, 0, 16, 5};
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < N; i++) d[i*DW +: DW] = (i < nz[k]) ? 16'd0 : 16'(i + 1);
        drive(1'b1, d, 2'b00, 4'd0, '0);
      end
    end
    idle(4);
    @(negedge clk);
    check("cnt_zeros", VW'(stat_zeros), VW'(24));
    check("cnt_beats", VW'(stat_beats), VW'(4));

    // Clear in the same cycle as an output transfer.
    drive(1'b1, bcast(0), 2'b00, 4'd0, '0);
    drive(1'b0, '0, 2'b00, 4'd0, '0);
    @(posedge clk); #1 stat_clear = 1'b1;
    @(negedge clk);
    check("clr_xfer_valid", VW'(bus.out_valid && bus.out_ready), VW'(1));
    @(posedge clk); #1 stat_clear = 1'b0;
    @(negedge clk);
    check("clr_beats", VW'(stat_beats), VW'(0));
    check("clr_zeros", VW'(stat_zeros), VW'(0));

    // Saturation on the 4-bit counter instance.
    @(posedge clk); #1 bb.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bb.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_beats", VW'(b_beats), VW'(15));
    check("sat_zeros", VW'(b_zeros), VW'(15));

    // Reset with two beats in flight after some counted traffic.
    drive(1'b1, bcast(9), 2'b01, 4'd0, '0);
    idle(3);
    drive(1'b1, bcast(11), 2'b00, 4'd0, '0);
    drive(1'b1, bcast(-12), 2'b01, 4'd0, '0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", VW'(bus.out_valid), VW'(0));
    check("midrst_beats", VW'(stat_beats), VW'(0));
    check("midrst_zeros", VW'(stat_zeros), VW'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    check("post_rst_out_valid", VW'(bus.out_valid), VW'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
